// File: rtl/scratch_writer.sv
// Loads filter words, then streams IF words into a circular scratchpad gated by free-cell credits.
// Writes are combinational on valid&ready; pointers and counts update on the next clock edge.
module scratch_writer #(
    parameter int IF_CELL_SIZE        = 8,
    parameter int FILTER_CELL_SIZE    = 8,
    parameter int IF_ADDRESS_SIZE     = 3,
    parameter int FILTER_ADDRESS_SIZE = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     filter_size,
    input  logic                           filter_valid,
    input  logic [FILTER_CELL_SIZE-1:0]    filter_data,
    output logic                           filter_ready,
    input  logic                           if_valid,
    input  logic [IF_CELL_SIZE-1:0]        if_data,
    input  logic                           if_last,
    output logic                           if_ready,
    input  logic                           if_free,
    output logic                           filter_wen,
    output logic [FILTER_ADDRESS_SIZE:0]   write_addr_filter,
    output logic [FILTER_CELL_SIZE-1:0]    filter_wdata,
    output logic                           if_wen,
    output logic [IF_ADDRESS_SIZE:0]       write_addr_if,
    output logic [IF_CELL_SIZE-1:0]        if_wdata,
    output logic [FILTER_ADDRESS_SIZE:0]   write_cnt_filter,
    output logic [IF_ADDRESS_SIZE:0]       write_cnt_if,
    output logic                           busy,
    output logic                           done
);

    // Common width for comparing the 3-bit filter_size against the filter cell count.
    localparam int TW = (FILTER_ADDRESS_SIZE + 1 > 3) ? FILTER_ADDRESS_SIZE + 1 : 3;

    localparam logic [IF_ADDRESS_SIZE:0]     IF_CELLS = {1'b1, {IF_ADDRESS_SIZE{1'b0}}};
    localparam logic [IF_ADDRESS_SIZE:0]     IF_LAST  = {1'b0, {IF_ADDRESS_SIZE{1'b1}}};
    localparam logic [IF_ADDRESS_SIZE:0]     IF_ONE   = {{IF_ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [FILTER_ADDRESS_SIZE:0] F_CELLS  = {1'b1, {FILTER_ADDRESS_SIZE{1'b0}}};
    localparam logic [FILTER_ADDRESS_SIZE:0] F_ONE    = {{FILTER_ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [TW-1:0]                T_ONE    = TW'(1);

    typedef enum logic [1:0] {IDLE, LOAD_FILTER, STREAM_IF, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [TW-1:0]             target_q, target_d;
    logic [FILTER_ADDRESS_SIZE:0] fcnt_q, fcnt_d, faddr_q, faddr_d;
    logic [IF_ADDRESS_SIZE:0]  icnt_q, icnt_d, iaddr_q, iaddr_d;

    logic [TW-1:0] fs_w;
    logic [TW-1:0] cells_w;
    logic          free_eff;

    assign fs_w     = TW'(filter_size);
    assign cells_w  = TW'(F_CELLS);
    assign free_eff = if_free && (icnt_q != '0);

    assign filter_ready = (state_q == LOAD_FILTER) && (TW'(fcnt_q) < target_q);
    assign if_ready     = (state_q == STREAM_IF) && (icnt_q < IF_CELLS);
    assign filter_wen   = filter_ready && filter_valid;
    assign if_wen       = if_ready && if_valid;

    assign filter_wdata      = filter_data;
    assign if_wdata          = if_data;
    assign write_addr_filter = faddr_q;
    assign write_cnt_filter  = fcnt_q;
    assign write_addr_if     = iaddr_q;
    assign write_cnt_if      = icnt_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == FINISH);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        fcnt_d   = fcnt_q;
        faddr_d  = faddr_q;
        icnt_d   = icnt_q;
        iaddr_d  = iaddr_q;

        // Free-cell credits are tracked in every state; accept and free together cancel.
        if (if_wen && !free_eff) begin
            icnt_d = icnt_q + IF_ONE;
        end else if (free_eff && !if_wen) begin
            icnt_d = icnt_q - IF_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_FILTER;
                    target_d = (fs_w < cells_w) ? fs_w : cells_w;
                    fcnt_d   = '0;
                    faddr_d  = '0;
                    icnt_d   = '0;
                    iaddr_d  = '0;
                end
            end
            LOAD_FILTER: begin
                if (target_q == '0) begin
                    state_d = STREAM_IF;
                end else if (filter_wen) begin
                    fcnt_d  = fcnt_q + F_ONE;
                    faddr_d = faddr_q + F_ONE;
                    if (TW'(fcnt_q) + T_ONE == target_q) begin
                        state_d = STREAM_IF;
                    end
                end
            end
            STREAM_IF: begin
                if (if_wen) begin
                    iaddr_d = (iaddr_q == IF_LAST) ? '0 : iaddr_q + IF_ONE;
                    if (if_last) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            fcnt_q   <= '0;
            faddr_q  <= '0;
            icnt_q   <= '0;
            iaddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            fcnt_q   <= fcnt_d;
            faddr_q  <= faddr_d;
            icnt_q   <= icnt_d;
            iaddr_q  <= iaddr_d;
        end
    end

endmodule

// File: tb/tb_scratch_writer.sv
// Directed bench for scratch_writer: inputs change on the falling edge, outputs sampled 1ns later.
module tb_scratch_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] filter_size;
    logic       filter_valid;
    logic [7:0] filter_data;
    logic       filter_ready;
    logic       if_valid;
    logic [7:0] if_data;
    logic       if_last;
    logic       if_ready;
    logic       if_free;
    logic       filter_wen;
    logic [3:0] write_addr_filter;
    logic [7:0] filter_wdata;
    logic       if_wen;
    logic [3:0] write_addr_if;
    logic [7:0] if_wdata;
    logic [3:0] write_cnt_filter;
    logic [3:0] write_cnt_if;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    scratch_writer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .filter_size       (filter_size),
        .filter_valid      (filter_valid),
        .filter_data       (filter_data),
        .filter_ready      (filter_ready),
        .if_valid          (if_valid),
        .if_data           (if_data),
        .if_last           (if_last),
        .if_ready          (if_ready),
        .if_free           (if_free),
        .filter_wen        (filter_wen),
        .write_addr_filter (write_addr_filter),
        .filter_wdata      (filter_wdata),
        .if_wen            (if_wen),
        .write_addr_if     (write_addr_if),
        .if_wdata          (if_wdata),
        .write_cnt_filter  (write_cnt_filter),
        .write_cnt_if      (write_cnt_if),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; filter_size = 3'd0; filter_valid = 1'b0; filter_data = 8'h00;
        if_valid = 1'b0; if_data = 8'h00; if_last = 1'b0; if_free = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt_f", 32'(write_cnt_filter), 32'd0);
        chk("rst_cnt_if", 32'(write_cnt_if), 32'd0);
        chk("rst_addr_if", 32'(write_addr_if), 32'd0);
        chk("rst_addr_f", 32'(write_addr_filter), 32'd0);
        chk("rst_rdy_f", 32'(filter_ready), 32'd0);
        chk("rst_rdy_if", 32'(if_ready), 32'd0);
        rst = 1'b0;

        // Three filter words with valid held high
        start = 1'b1; filter_size = 3'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            filter_valid = 1'b1; filter_data = 8'hA0 + 8'(k);
            #1;
            chk("f_wen", 32'(filter_wen), 32'd1);
            chk("f_addr", 32'(write_addr_filter), 32'(k));
            chk("f_wdata", 32'(filter_wdata), 32'hA0 + 32'(k));
            @(negedge clk);
        end
        #1;
        chk("f_cnt3", 32'(write_cnt_filter), 32'd3);
        chk("f_wen_off", 32'(filter_wen), 32'd0);
        chk("if_rdy_on", 32'(if_ready), 32'd1);
        chk("busy_stream", 32'(busy), 32'd1);

        // Fill all 8 IF cells, then one more after a single free
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1; if_data = 8'h10 + 8'(i);
            #1;
            chk("if_wen", 32'(if_wen), 32'd1);
            chk("if_addr", 32'(write_addr_if), 32'(i));
            chk("if_wdata", 32'(if_wdata), 32'h10 + 32'(i));
            @(negedge clk);
        end
        start = 1'b1; if_data = 8'h18;
        #1;
        chk("full_rdy", 32'(if_ready), 32'd0);
        chk("full_wen", 32'(if_wen), 32'd0);
        chk("full_cnt", 32'(write_cnt_if), 32'd8);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_ignored", 32'(write_cnt_if), 32'd8);
        if_free = 1'b1;
        @(negedge clk);
        if_free = 1'b0;
        #1;
        chk("free_cnt7", 32'(write_cnt_if), 32'd7);
        chk("free_rdy", 32'(if_ready), 32'd1);
        chk("ninth_wen", 32'(if_wen), 32'd1);
        chk("ninth_addr", 32'(write_addr_if), 32'd0);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("cnt8_again", 32'(write_cnt_if), 32'd8);
        chk("addr_after_wrap", 32'(write_addr_if), 32'd1);

        // Accept and free in the same cycle at count 5
        if_free = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("cnt5", 32'(write_cnt_if), 32'd5);
        if_valid = 1'b1; if_data = 8'h55;
        #1;
        chk("both_wen", 32'(if_wen), 32'd1);
        @(negedge clk);
        if_valid = 1'b0; if_free = 1'b0;
        #1;
        chk("both_cnt", 32'(write_cnt_if), 32'd5);
        chk("both_addr", 32'(write_addr_if), 32'd2);

        // Last word ends the sequence
        if_valid = 1'b1; if_last = 1'b1; if_data = 8'h77;
        #1;
        chk("last_wen", 32'(if_wen), 32'd1);
        @(negedge clk);
        if_valid = 1'b0; if_last = 1'b0; filter_valid = 1'b0;
        #1;
        chk("done_hi", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_cnt", 32'(write_cnt_if), 32'd6);
        @(negedge clk);
        #1;
        chk("done_lo", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("f_cnt_hold", 32'(write_cnt_filter), 32'd3);
        if_free = 1'b1;
        @(negedge clk);
        if_free = 1'b0;
        #1;
        chk("idle_free", 32'(write_cnt_if), 32'd5);

        // filter_size 0: no filter writes, two IF words
        start = 1'b1; filter_size = 3'd0; filter_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("fs0_rdy", 32'(filter_ready), 32'd0);
        chk("fs0_wen", 32'(filter_wen), 32'd0);
        chk("fs0_busy", 32'(busy), 32'd1);
        chk("fs0_cnt_clr", 32'(write_cnt_if), 32'd0);
        @(negedge clk);
        #1;
        chk("fs0_if_rdy", 32'(if_ready), 32'd1);
        chk("fs0_f_wen", 32'(filter_wen), 32'd0);
        if_valid = 1'b1; if_data = 8'h21;
        #1;
        chk("fs0_wen1", 32'(if_wen), 32'd1);
        chk("fs0_addr1", 32'(write_addr_if), 32'd0);
        @(negedge clk);
        if_data = 8'h22; if_last = 1'b1;
        #1;
        chk("fs0_wen2", 32'(if_wen), 32'd1);
        chk("fs0_addr2", 32'(write_addr_if), 32'd1);
        @(negedge clk);
        if_valid = 1'b0; if_last = 1'b0; filter_valid = 1'b0;
        #1;
        chk("fs0_done", 32'(done), 32'd1);
        chk("fs0_fcnt", 32'(write_cnt_filter), 32'd0);
        chk("fs0_icnt", 32'(write_cnt_if), 32'd2);
        @(negedge clk);
        #1;
        chk("fs0_done_lo", 32'(done), 32'd0);
        chk("fs0_busy_lo", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of STREAM_IF at count 4
        start = 1'b1; filter_size = 3'd1;
        @(negedge clk);
        start = 1'b0; filter_valid = 1'b1; filter_data = 8'hF1;
        #1;
        chk("r_f_wen", 32'(filter_wen), 32'd1);
        @(negedge clk);
        filter_valid = 1'b0; if_valid = 1'b1;
        repeat (4) @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("r_cnt4", 32'(write_cnt_if), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cnt_if", 32'(write_cnt_if), 32'd0);
        chk("ar_addr_if", 32'(write_addr_if), 32'd0);
        chk("ar_cnt_f", 32'(write_cnt_filter), 32'd0);
        chk("ar_addr_f", 32'(write_addr_filter), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rdy", 32'(if_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; filter_size = 3'd2;
        @(negedge clk);
        start = 1'b0; filter_valid = 1'b1; filter_data = 8'hB0;
        #1;
        chk("pr_wen", 32'(filter_wen), 32'd1);
        chk("pr_addr0", 32'(write_addr_filter), 32'd0);
        chk("pr_cnt0", 32'(write_cnt_filter), 32'd0);
        @(negedge clk);
        filter_data = 8'hB1;
        #1;
        chk("pr_addr1", 32'(write_addr_filter), 32'd1);
        @(negedge clk);
        filter_valid = 1'b0;
        #1;
        chk("pr_cnt2", 32'(write_cnt_filter), 32'd2);
        chk("pr_if_rdy", 32'(if_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
